// File: rtl/request_demux8_pkg.sv
// Shared types and constants for the 1-to-8 request demultiplexer.
package request_demux8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam int unsigned TIMER_W = 8;

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'(1) << idx;
  endfunction

endpackage

// File: rtl/request_demux8_multiplexer8.sv
// 8-way slice selector over a packed bus of eight WIDTH-bit words.
module multiplexer8 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [8*WIDTH-1:0] data_i,
  input  logic [2:0]         sel_i,
  output logic [WIDTH-1:0]   data_o
);

  always_comb begin
    data_o = data_i[sel_i*WIDTH +: WIDTH];
  end

endmodule

// File: rtl/request_demux8.sv
// Routes one initiator request to one of eight responder ports and returns
// that port's response; one transaction in flight, per-transaction timeout.
module request_demux8
  import request_demux8_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_sel,
  input  logic                 req_we,
  input  logic [WIDTH-1:0]     req_addr,
  input  logic [WIDTH-1:0]     req_wdata,
  output logic                 resp_valid,
  output logic                 resp_err,
  output logic [WIDTH-1:0]     resp_rdata,
  output logic [7:0]           dn_req_valid,
  input  logic [7:0]           dn_req_ready,
  output logic                 dn_we,
  output logic [WIDTH-1:0]     dn_addr,
  output logic [WIDTH-1:0]     dn_wdata,
  input  logic [7:0]           dn_resp_valid,
  input  logic [8*WIDTH-1:0]   dn_resp_rdata
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [2:0]           sel_q, sel_d;
  logic                 we_q, we_d;
  logic [WIDTH-1:0]     addr_q, addr_d;
  logic [WIDTH-1:0]     wdata_q, wdata_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 err_q, err_d;
  logic [WIDTH-1:0]     rdata_q, rdata_d;
  logic [WIDTH-1:0]     sel_rdata;

  multiplexer8 #(.WIDTH(WIDTH)) u_rdata_mux (
    .data_i (dn_resp_rdata),
    .sel_i  (sel_q),
    .data_o (sel_rdata)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    timer_d = timer_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          sel_d   = req_sel;
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (dn_req_ready[sel_q]) begin
          if (we_q) begin
            err_d   = 1'b0;
            rdata_d = '0;
            state_d = ST_RESP;
          end else begin
            timer_d = '0;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // The strobe is tested first so it wins over a coincident timeout.
        if (dn_resp_valid[sel_q]) begin
          err_d   = 1'b0;
          rdata_d = sel_rdata;
          state_d = ST_RESP;
        end else if (timer_q == TIMER_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_RESP;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    req_ready    = (state_q == ST_IDLE);
    resp_valid   = (state_q == ST_RESP);
    resp_err     = err_q;
    resp_rdata   = rdata_q;
    dn_req_valid = (state_q == ST_ISSUE) ? onehot8(sel_q) : '0;
    dn_we        = we_q;
    dn_addr      = addr_q;
    dn_wdata     = wdata_q;
  end

endmodule

// File: tb/tb_request_demux8.sv
// Randomized self-checking bench for request_demux8 against a per-transaction
// latency/response model.
module tb_request_demux8;

  localparam int unsigned WIDTH   = 32;
  localparam int          TIMEOUT = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_sel;
  logic              req_we;
  logic [WIDTH-1:0]  req_addr;
  logic [WIDTH-1:0]  req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [WIDTH-1:0]  resp_rdata;
  logic [7:0]        dn_req_valid;
  logic [7:0]        dn_req_ready;
  logic              dn_we;
  logic [WIDTH-1:0]  dn_addr;
  logic [WIDTH-1:0]  dn_wdata;
  logic [7:0]        dn_resp_valid;
  logic [8*WIDTH-1:0] dn_resp_rdata;

  int unsigned checks = 0;
  int unsigned errors = 0;

  request_demux8 #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_sel       (req_sel),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_err      (resp_err),
    .resp_rdata    (resp_rdata),
    .dn_req_valid  (dn_req_valid),
    .dn_req_ready  (dn_req_ready),
    .dn_we         (dn_we),
    .dn_addr       (dn_addr),
    .dn_wdata      (dn_wdata),
    .dn_resp_valid (dn_resp_valid),
    .dn_resp_rdata (dn_resp_rdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bit_of(input logic [2:0] s);
    logic [7:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Random traffic on every port except the selected one.
  task automatic drive_noise(input logic [2:0] sel);
    dn_req_ready  = 8'($urandom) & ~bit_of(sel);
    dn_resp_valid = 8'($urandom) & ~bit_of(sel);
    for (int i = 0; i < 8; i++) dn_resp_rdata[i*WIDTH +: WIDTH] = $urandom;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rdy"},    req_ready,    1'b1);
    check({tag, "_dnv"},    dn_req_valid, 8'h00);
    check({tag, "_rv"},     resp_valid,   1'b0);
    check({tag, "_err"},    resp_err,     1'b0);
    check({tag, "_rdata"},  resp_rdata,   '0);
    check({tag, "_addr"},   dn_addr,      '0);
    check({tag, "_wdata"},  dn_wdata,     '0);
    check({tag, "_we"},     dn_we,        1'b0);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      req_valid = 1'b0;
      drive_noise(3'($urandom));
      @(negedge clock);
      check("idle_rdy", req_ready,    1'b1);
      check("idle_rv",  resp_valid,   1'b0);
      check("idle_dnv", dn_req_valid, 8'h00);
      next_cycle();
    end
  endtask

  // Called at posedge+1 of the accept cycle; returns at posedge+1 of the cycle
  // after the response pulse. rd: cycles the port holds ready low; sd: WAIT
  // cycle index of the response strobe (<0 or >=TIMEOUT means none in time).
  task automatic run_txn(input logic we, input logic [2:0] sel,
                         input logic [WIDTH-1:0] addr, input logic [WIDTH-1:0] wdata,
                         input int rd, input int sd, input logic [WIDTH-1:0] data,
                         input logic early, input logic hold);
    int         jr;
    logic       exp_err;
    logic [WIDTH-1:0] exp_rdata;
    if (we) begin
      jr = rd + 1;          exp_err = 1'b0; exp_rdata = '0;
    end else if (sd >= 0 && sd < TIMEOUT) begin
      jr = rd + 2 + sd;     exp_err = 1'b0; exp_rdata = data;
    end else begin
      jr = rd + 1 + TIMEOUT; exp_err = 1'b1; exp_rdata = '0;
    end

    req_valid = 1'b1; req_we = we; req_sel = sel; req_addr = addr; req_wdata = wdata;
    drive_noise(sel);
    @(negedge clock);
    check("acc_rdy", req_ready,  1'b1);
    check("acc_rv",  resp_valid, 1'b0);

    for (int j = 0; j <= jr; j++) begin
      next_cycle();
      req_valid = hold ? 1'b1 : 1'($urandom);
      req_we    = 1'($urandom);
      req_sel   = 3'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      drive_noise(sel);
      dn_req_ready[sel] = (j == rd);
      if ((!we && sd >= 0 && j == rd + 1 + sd) || (early && j == rd)) begin
        dn_resp_valid[sel] = 1'b1;
        if (j != rd) dn_resp_rdata[sel*WIDTH +: WIDTH] = data;
      end
      @(negedge clock);
      check("busy_rdy", req_ready,  1'b0);
      check("rv",       resp_valid, (j == jr));
      check("dnv",      dn_req_valid, (j <= rd) ? bit_of(sel) : 8'h00);
      if (j <= rd) begin
        check("dn_addr",  dn_addr,  addr);
        check("dn_wdata", dn_wdata, wdata);
        check("dn_we",    dn_we,    we);
      end
      if (j == jr) begin
        check("resp_err",   resp_err,   exp_err);
        check("resp_rdata", resp_rdata, exp_rdata);
      end
    end
    next_cycle();
  endtask

  task automatic run_reset_txn(input logic [2:0] sel, input int k, input logic [WIDTH-1:0] data);
    req_valid = 1'b1; req_we = 1'b0; req_sel = sel; req_addr = $urandom; req_wdata = $urandom;
    drive_noise(sel);
    @(negedge clock);
    check("racc_rdy", req_ready, 1'b1);
    next_cycle();
    req_valid = 1'b0;
    drive_noise(sel);
    dn_req_ready[sel] = 1'b1;
    @(negedge clock);
    check("rissue_dnv", dn_req_valid, bit_of(sel));
    for (int i = 0; i <= k; i++) begin
      next_cycle();
      drive_noise(sel);
      reset = (i == k);
      @(negedge clock);
      check("rwait_rv", resp_valid, 1'b0);
    end
    next_cycle();
    reset = 1'b0;
    drive_noise(sel);
    dn_resp_valid[sel] = 1'b1;
    dn_resp_rdata[sel*WIDTH +: WIDTH] = data;
    @(negedge clock);
    check_reset_state("mid_rst");
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive_noise(sel);
      dn_resp_valid[sel] = 1'b1;
      @(negedge clock);
      check("late_rv",  resp_valid, 1'b0);
      check("late_rdy", req_ready,  1'b1);
      next_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_sel = '0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0;
    drive_noise(3'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_state("rst");
    next_cycle();
    reset = 1'b0;
    idle(2);

    run_txn(1'b1, 3'd5, 32'h40, 32'hDEADBEEF, 0, -1, '0, 1'b0, 1'b0);
    idle(1);
    run_txn(1'b0, 3'd2, 32'h100, 32'h0, 3, 2, 32'h12345678, 1'b0, 1'b0);
    idle(1);
    run_txn(1'b0, 3'd7, 32'h200, 32'h0, 0, -1, 32'hAAAA5555, 1'b0, 1'b0);
    run_txn(1'b0, 3'd0, 32'h300, 32'h0, 1, TIMEOUT - 1, 32'hCAFEF00D, 1'b0, 1'b0);
    run_txn(1'b0, 3'd4, 32'h310, 32'h0, 0, -1, 32'h13572468, 1'b1, 1'b0);
    run_reset_txn(3'd6, 2, 32'h0BADF00D);
    run_txn(1'b1, 3'd1, 32'h400, 32'h11111111, 0, -1, '0, 1'b0, 1'b1);
    run_txn(1'b1, 3'd3, 32'h404, 32'h22222222, 0, -1, '0, 1'b0, 1'b1);
    run_txn(1'b0, 3'd3, 32'h408, 32'h0, 0, 0, 32'h33333333, 1'b0, 1'b1);

    for (int t = 0; t < 60; t++) begin
      run_txn(1'($urandom), 3'($urandom), $urandom, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 5)) - 1,
              $urandom, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
